// File: rtl/debug_mem_arbiter.sv
// Debug/CPU memory arbiter: captures single-cycle debug strobes and merges
// them with the CPU memory port onto one single-port synchronous RAM.
// A pending debug op yields to the CPU for at most MAX_WAIT cycles.
module debug_mem_arbiter #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic              clk,
  input  logic              rst_p,
  input  logic              dbg_ce,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_done,
  output logic              dbg_busy,
  output logic              dbg_overrun,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              mem_ce,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned    WC_W     = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [WC_W-1:0] WAIT_LIM = WC_W'(MAX_WAIT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  logic [WC_W-1:0]   wait_cnt;
  logic              op_we;
  logic [ADDR_W-1:0] op_addr;
  logic [DATA_W-1:0] op_wdata;
  logic [DATA_W-1:0] rdata_q;
  logic              done_q;
  logic              overrun_q;
  logic              rvalid_q;
  logic              dbg_win;

  assign dbg_win = (state == PEND) && (!cpu_req || (wait_cnt == WAIT_LIM));

  // RAM port mux: debug wins when granted, otherwise CPU passes through; idle bus driven to zero
  always_comb begin
    cpu_gnt   = 1'b0;
    mem_ce    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (!rst_p) begin
      if (dbg_win) begin
        mem_ce    = 1'b1;
        mem_we    = op_we;
        mem_addr  = op_addr;
        mem_wdata = op_wdata;
      end else if (cpu_req) begin
        cpu_gnt   = 1'b1;
        mem_ce    = 1'b1;
        mem_we    = cpu_we;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
      end
    end
  end

  // Debug op sequencing: accept, wait for grant, complete
  always_ff @(posedge clk or posedge rst_p) begin
    if (rst_p) begin
      state    <= IDLE;
      wait_cnt <= '0;
      op_we    <= 1'b0;
      op_addr  <= '0;
      op_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (dbg_ce) begin
            op_we    <= dbg_we;
            op_addr  <= dbg_addr;
            op_wdata <= dbg_wdata;
            wait_cnt <= '0;
            state    <= PEND;
          end
        end
        PEND: begin
          if (dbg_win) begin
            wait_cnt <= '0;
            state    <= DONE;
          end else begin
            // not winning implies cpu_req with wait_cnt below the limit, so no overflow
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Completion pulse, held read result, sticky overrun and CPU read-valid
  always_ff @(posedge clk or posedge rst_p) begin
    if (rst_p) begin
      done_q    <= 1'b0;
      rdata_q   <= '0;
      overrun_q <= 1'b0;
      rvalid_q  <= 1'b0;
    end else begin
      done_q   <= dbg_win;
      rvalid_q <= cpu_gnt && !cpu_we;
      if ((state == DONE) && !op_we) begin
        rdata_q <= mem_rdata;
      end
      if (dbg_ce && (state != IDLE)) begin
        overrun_q <= 1'b1;
      end
    end
  end

  // Read data is forwarded in the done cycle so it is valid alongside dbg_done, then held
  assign dbg_rdata   = ((state == DONE) && !op_we) ? mem_rdata : rdata_q;
  assign dbg_done    = done_q;
  assign dbg_busy    = (state != IDLE);
  assign dbg_overrun = overrun_q;
  assign cpu_rvalid  = rvalid_q;
  assign cpu_rdata   = mem_rdata;

endmodule

// File: tb/tb_debug_mem_arbiter.sv
// Self-checking bench for debug_mem_arbiter: RAM models, scoreboard queues
// for CPU and debug read data, and one task per scenario.
module tb_debug_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_p;
  logic          dbg_ce, dbg_ce_b, dbg_we;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_wdata;
  logic          cpu_req, cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;

  logic [DW-1:0] dbg_rdata, cpu_rdata, mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic [AW-1:0] mem_addr;
  logic          dbg_done, dbg_busy, dbg_overrun, cpu_gnt, cpu_rvalid, mem_ce, mem_we;

  logic [DW-1:0] dbg_rdata_b, cpu_rdata_b, mem_wdata_b;
  logic [DW-1:0] mem_rdata_b = '0;
  logic [AW-1:0] mem_addr_b;
  logic          dbg_done_b, dbg_busy_b, dbg_overrun_b, cpu_gnt_b, cpu_rvalid_b, mem_ce_b, mem_we_b;

  logic [DW-1:0] ram_a [0:255];
  logic [DW-1:0] ram_b [0:255];

  logic [DW-1:0] cpu_q [$];
  logic [DW-1:0] dbg_q [$];
  int checks = 0;
  int errors = 0;
  int rvalid_cnt = 0;

  debug_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(8)) dut_a (
    .clk(clk), .rst_p(rst_p),
    .dbg_ce(dbg_ce), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_rdata(dbg_rdata), .dbg_done(dbg_done), .dbg_busy(dbg_busy), .dbg_overrun(dbg_overrun),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  debug_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(0)) dut_b (
    .clk(clk), .rst_p(rst_p),
    .dbg_ce(dbg_ce_b), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_rdata(dbg_rdata_b), .dbg_done(dbg_done_b), .dbg_busy(dbg_busy_b), .dbg_overrun(dbg_overrun_b),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt_b), .cpu_rvalid(cpu_rvalid_b), .cpu_rdata(cpu_rdata_b),
    .mem_ce(mem_ce_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
    .mem_rdata(mem_rdata_b)
  );

  // Synchronous single-port RAMs with 1-cycle read latency
  always @(posedge clk) begin
    if (mem_ce) begin
      if (mem_we) ram_a[mem_addr[7:0]] <= mem_wdata;
      else        mem_rdata <= ram_a[mem_addr[7:0]];
    end
    if (mem_ce_b) begin
      if (mem_we_b) ram_b[mem_addr_b[7:0]] <= mem_wdata_b;
      else          mem_rdata_b <= ram_b[mem_addr_b[7:0]];
    end
  end

  // Scoreboard: pop expected data whenever instance A reports a result
  always @(negedge clk) begin
    logic [DW-1:0] exp;
    if (cpu_rvalid) begin
      checks++;
      rvalid_cnt++;
      if (cpu_q.size() == 0) begin
        errors++;
        $display("FAIL cpu_rvalid_unexpected: got rvalid with data %h, expected none", cpu_rdata);
      end else begin
        exp = cpu_q.pop_front();
        if (cpu_rdata !== exp) begin
          errors++;
          $display("FAIL cpu_rdata: got %h expected %h", cpu_rdata, exp);
        end
      end
    end
    if (dbg_done) begin
      checks++;
      if (dbg_q.size() == 0) begin
        errors++;
        $display("FAIL dbg_done_unexpected: got dbg_done with rdata %h, expected none", dbg_rdata);
      end else begin
        exp = dbg_q.pop_front();
        if (dbg_rdata !== exp) begin
          errors++;
          $display("FAIL dbg_rdata_at_done: got %h expected %h", dbg_rdata, exp);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if (dbg_busy !== 1'b0)    begin errors++; $display("FAIL rst_busy: got %b expected 0", dbg_busy); end
    checks++; if (dbg_done !== 1'b0)    begin errors++; $display("FAIL rst_done: got %b expected 0", dbg_done); end
    checks++; if (dbg_overrun !== 1'b0) begin errors++; $display("FAIL rst_overrun: got %b expected 0", dbg_overrun); end
    checks++; if (dbg_rdata !== '0)     begin errors++; $display("FAIL rst_rdata: got %h expected 0", dbg_rdata); end
    checks++; if (cpu_rvalid !== 1'b0)  begin errors++; $display("FAIL rst_rvalid: got %b expected 0", cpu_rvalid); end
    checks++; if (mem_ce !== 1'b0 || mem_addr !== '0) begin errors++; $display("FAIL rst_mem: got ce %b addr %h expected 0 0", mem_ce, mem_addr); end
    @(posedge clk); #1 rst_p = 1'b0;
  endtask

  task automatic test_read_idle();
    cpu_req = 1'b0;
    dbg_q.push_back(32'hCAFEF00D);
    dbg_we = 1'b0; dbg_addr = 32'h10; dbg_ce = 1'b1;
    @(posedge clk); #1 dbg_ce = 1'b0;
    @(negedge clk);
    checks++; if (dbg_busy !== 1'b1) begin errors++; $display("FAIL rd_busy_k1: got %b expected 1", dbg_busy); end
    checks++; if (mem_ce !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h10) begin
      errors++; $display("FAIL rd_mem_k1: got ce %b we %b addr %h expected 1 0 00000010", mem_ce, mem_we, mem_addr); end
    checks++; if (dbg_done !== 1'b0) begin errors++; $display("FAIL rd_done_k1: got %b expected 0", dbg_done); end
    @(negedge clk);
    checks++; if (dbg_done !== 1'b1 || dbg_busy !== 1'b1) begin
      errors++; $display("FAIL rd_done_k2: got done %b busy %b expected 1 1", dbg_done, dbg_busy); end
    @(negedge clk);
    checks++; if (dbg_busy !== 1'b0 || dbg_rdata !== 32'hCAFEF00D) begin
      errors++; $display("FAIL rd_hold_k3: got busy %b rdata %h expected 0 cafef00d", dbg_busy, dbg_rdata); end
  endtask

  task automatic test_write_contended();
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h80; cpu_wdata = 32'h55;
    dbg_q.push_back(32'hCAFEF00D);
    dbg_we = 1'b1; dbg_addr = 32'h20; dbg_wdata = 32'h12345678; dbg_ce = 1'b1;
    @(negedge clk);
    checks++; if (cpu_gnt !== 1'b1) begin errors++; $display("FAIL wr_gnt_accept: got %b expected 1", cpu_gnt); end
    @(posedge clk); #1 dbg_ce = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++; if (cpu_gnt !== 1'b1 || mem_addr !== 32'h80) begin
        errors++; $display("FAIL wr_cpu_gnt_%0d: got gnt %b addr %h expected 1 00000080", i, cpu_gnt, mem_addr); end
    end
    @(negedge clk);
    checks++; if (cpu_gnt !== 1'b0 || mem_ce !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h20 || mem_wdata !== 32'h12345678) begin
      errors++; $display("FAIL wr_dbg_grant: got gnt %b ce %b we %b addr %h data %h expected 0 1 1 00000020 12345678",
                         cpu_gnt, mem_ce, mem_we, mem_addr, mem_wdata); end
    @(negedge clk);
    checks++; if (dbg_done !== 1'b1) begin errors++; $display("FAIL wr_done: got %b expected 1", dbg_done); end
    checks++; if (ram_a[8'h20] !== 32'h12345678) begin errors++; $display("FAIL wr_ram: got %h expected 12345678", ram_a[8'h20]); end
    @(posedge clk); #1 cpu_req = 1'b0; cpu_we = 1'b0;
  endtask

  task automatic test_overrun();
    dbg_q.push_back(32'hCAFEF00D);
    dbg_we = 1'b0; dbg_addr = 32'h10; dbg_ce = 1'b1;
    @(posedge clk); #1 dbg_addr = 32'h20;
    @(negedge clk);
    checks++; if (mem_addr !== 32'h10 || dbg_overrun !== 1'b0) begin
      errors++; $display("FAIL ovr_k1: got addr %h overrun %b expected 00000010 0", mem_addr, dbg_overrun); end
    @(posedge clk); #1 dbg_ce = 1'b0;
    @(negedge clk);
    checks++; if (dbg_overrun !== 1'b1 || dbg_done !== 1'b1) begin
      errors++; $display("FAIL ovr_k2: got overrun %b done %b expected 1 1", dbg_overrun, dbg_done); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (dbg_overrun !== 1'b1 || mem_ce !== 1'b0 || dbg_busy !== 1'b0) begin
        errors++; $display("FAIL ovr_sticky_%0d: got overrun %b ce %b busy %b expected 1 0 0", i, dbg_overrun, mem_ce, dbg_busy); end
    end
  endtask

  task automatic test_interleave();
    logic       req_t [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [7:0] adr_t [6] = '{8'd0, 8'd1, 8'd0, 8'd2, 8'd3, 8'd0};
    int start_cnt;
    start_cnt = rvalid_cnt;
    for (int i = 0; i < 4; i++) ram_a[i] = 32'h1111_0000 + i;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      cpu_req = req_t[c]; cpu_we = 1'b0; cpu_addr = {24'h0, adr_t[c]};
      dbg_ce = (c == 0);
      if (c == 0) begin
        dbg_we = 1'b0; dbg_addr = 32'h10;
        dbg_q.push_back(32'hCAFEF00D);
      end
      if (req_t[c]) cpu_q.push_back(ram_a[adr_t[c]]);
      @(negedge clk);
      checks++; if (cpu_gnt !== req_t[c]) begin errors++; $display("FAIL il_gnt_c%0d: got %b expected %b", c, cpu_gnt, req_t[c]); end
      if (c == 2) begin
        checks++; if (mem_ce !== 1'b1 || mem_addr !== 32'h10) begin
          errors++; $display("FAIL il_dbg_grant: got ce %b addr %h expected 1 00000010", mem_ce, mem_addr); end
      end
    end
    @(posedge clk); #1 cpu_req = 1'b0; dbg_ce = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (rvalid_cnt - start_cnt != 4 || cpu_q.size() != 0 || dbg_q.size() != 0) begin
      errors++; $display("FAIL il_drain: got rvalids %0d cpu_q %0d dbg_q %0d expected 4 0 0",
                         rvalid_cnt - start_cnt, cpu_q.size(), dbg_q.size()); end
  endtask

  task automatic test_reset_mid();
    bit seen;
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h80; cpu_wdata = 32'h66;
    dbg_we = 1'b0; dbg_addr = 32'h10; dbg_ce = 1'b1;
    @(posedge clk); #1 dbg_ce = 1'b0;
    @(negedge clk);
    checks++; if (dbg_busy !== 1'b1 || cpu_gnt !== 1'b1) begin
      errors++; $display("FAIL rm_pend: got busy %b gnt %b expected 1 1", dbg_busy, cpu_gnt); end
    #1 rst_p = 1'b1;
    #1;
    checks++; if (dbg_busy !== 1'b0 || dbg_done !== 1'b0 || dbg_overrun !== 1'b0 || dbg_rdata !== '0 ||
                  mem_ce !== 1'b0 || cpu_gnt !== 1'b0 || mem_we !== 1'b0 || mem_addr !== '0 || cpu_rvalid !== 1'b0) begin
      errors++; $display("FAIL rm_outputs: got busy %b done %b ovr %b rdata %h ce %b gnt %b we %b addr %h rvalid %b expected all 0",
                         dbg_busy, dbg_done, dbg_overrun, dbg_rdata, mem_ce, cpu_gnt, mem_we, mem_addr, cpu_rvalid); end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++; if (mem_ce !== 1'b0) begin errors++; $display("FAIL rm_ram_idle_%0d: got ce %b expected 0", i, mem_ce); end
    end
    @(posedge clk); #1 rst_p = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    dbg_q.push_back(32'hCAFEF00D);
    dbg_addr = 32'h10; dbg_ce = 1'b1;
    @(posedge clk); #1 dbg_ce = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (dbg_done) seen = 1'b1;
    end
    checks++; if (!seen) begin errors++; $display("FAIL rm_next_op: got no dbg_done within 10 cycles expected done"); end
  endtask

  task automatic test_maxwait0();
    ram_b[8'h30] = 32'hA5A50003;
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h84; cpu_wdata = 32'h0;
    dbg_we = 1'b0; dbg_addr = 32'h30; dbg_ce_b = 1'b1;
    @(negedge clk);
    checks++; if (cpu_gnt_b !== 1'b1) begin errors++; $display("FAIL mw0_gnt_accept: got %b expected 1", cpu_gnt_b); end
    @(posedge clk); #1 dbg_ce_b = 1'b0;
    @(negedge clk);
    checks++; if (cpu_gnt_b !== 1'b0 || mem_ce_b !== 1'b1 || mem_we_b !== 1'b0 || mem_addr_b !== 32'h30 ||
                  dbg_busy_b !== 1'b1 || dbg_overrun_b !== 1'b0) begin
      errors++; $display("FAIL mw0_grant_k1: got gnt %b ce %b we %b addr %h busy %b ovr %b expected 0 1 0 00000030 1 0",
                         cpu_gnt_b, mem_ce_b, mem_we_b, mem_addr_b, dbg_busy_b, dbg_overrun_b); end
    @(negedge clk);
    checks++; if (dbg_done_b !== 1'b1 || dbg_rdata_b !== 32'hA5A50003 || cpu_gnt_b !== 1'b1) begin
      errors++; $display("FAIL mw0_done_k2: got done %b rdata %h gnt %b expected 1 a5a50003 1",
                         dbg_done_b, dbg_rdata_b, cpu_gnt_b); end
    @(posedge clk); #1 cpu_req = 1'b0; cpu_we = 1'b0;
  endtask

  initial begin
    rst_p = 1'b1;
    dbg_ce = 1'b0; dbg_ce_b = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    for (int i = 0; i < 256; i++) begin
      ram_a[i] = 32'h0;
      ram_b[i] = 32'h0;
    end
    ram_a[8'h10] = 32'hCAFEF00D;

    test_reset();
    test_read_idle();
    test_write_contended();
    test_overrun();
    test_interleave();
    test_reset_mid();
    test_maxwait0();

    repeat (3) @(negedge clk);
    checks++; if (cpu_q.size() != 0 || dbg_q.size() != 0) begin
      errors++; $display("FAIL final_drain: got cpu_q %0d dbg_q %0d expected 0 0", cpu_q.size(), dbg_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
